btn_bank: RTL and testbench
===========================

# btn_bank

Parametrised multi-channel push-button front end: each of `N_BTN` raw inputs is synchronised, debounced, and decoded into a stable level, press and release pulses, a long-press pulse and a per-channel toggle. It sits directly behind board button pins and feeds user-interface logic such as LED control and mode selection, replacing the single-button debounce-and-toggle block.

## Interface
- `N_BTN`, 4: number of independent button channels (≥1)
- `DB_CYCLES`, 100000: consecutive cycles a new level must persist before acceptance (≥2)
- `LONG_CYCLES`, 50000000: cycles the debounced level must stay pressed before `long_pulse` fires (≥1)
- `ACTIVE_LOW`, 0: 1 = pressed pin reads 0; raw inputs are inverted before synchronisation
- `clk` in 1: single system clock
- `rst_n` in 1: asynchronous, active-low reset
- `btn_raw` in N_BTN: raw, asynchronous button pins
- `btn_level` out N_BTN: debounced level, 1 = pressed
- `press_pulse` out N_BTN: one-cycle pulse on each debounced press
- `release_pulse` out N_BTN: one-cycle pulse on each debounced release
- `long_pulse` out N_BTN: one-cycle pulse when a press has been held `LONG_CYCLES` cycles
- `toggle` out N_BTN: flips on every `press_pulse`

## Operation
- Channels are fully independent. No shared state.
- Polarity: `pin = ACTIVE_LOW ? ~btn_raw[i] : btn_raw[i]`.
- Sync: two flops, s1 then s2. Both reset to 0, the released level.
- Debounce: state `db` (reset 0) and counter `dcnt`, width `$clog2(DB_CYCLES)`, reset 0.
  - When s2 == db: dcnt <= 0.
  - Otherwise dcnt increments. When dcnt == DB_CYCLES-1: db <= s2 and dcnt <= 0.
  - Any bounce back to db before acceptance clears dcnt. Partial counts never carry over.
- Edge detect: `db_q` is db delayed by one cycle.
  - press_pulse <= db & ~db_q
  - release_pulse <= ~db & db_q
  - Both are registered and never high together.
- Toggle: toggle <= toggle ^ (db & ~db_q). It updates on the same edge as press_pulse.
- Long-press: counter `lcnt`, width `$clog2(LONG_CYCLES+1)`, reset 0.
  - Clears while db == 0.
  - Increments while db == 1 and saturates at LONG_CYCLES.
  - long_pulse <= (db & lcnt == LONG_CYCLES-1). It fires exactly once per press, with no auto-repeat.
  - Release before saturation gives no long_pulse.
- `btn_level` = db.
- Reset values: all outputs 0, all counters 0. Reset mid-debounce or mid-hold discards the progress. After reset, a button held through reset is re-accepted as a fresh press.

## Timing
- Edge numbering: edge 0 is the first clock edge at which s1 samples the new pin level, and the pin stays stable afterwards.
- Accept:
  - s2 is updated at edge 1.
  - db updates at edge DB_CYCLES+1, and btn_level changes then.
- Pulse: press_pulse or release_pulse is high for exactly one cycle, following edge DB_CYCLES+2. toggle changes at edge DB_CYCLES+2.
- Long: long_pulse is high for one cycle, following edge DB_CYCLES+1+LONG_CYCLES. That is LONG_CYCLES-1 cycles after the press_pulse cycle.
- Glitch rejection:
  - A pin excursion lasting ≤ DB_CYCLES-1 sampled cycles (after sync) produces no output change.
  - An excursion of exactly DB_CYCLES cycles is accepted.
- Minimum event spacing:
  - A release followed by a re-press needs ≥ DB_CYCLES stable cycles per phase.
  - Back-to-back accepted presses give distinct pulses at least 2·DB_CYCLES cycles apart.
- Simultaneous channels: presses on several channels in the same cycle produce same-cycle pulses on each channel. There is no arbitration.

## Structure
- Package `btn_pkg`:
  - default constants `BTN_DB_CYCLES_DEF` and `BTN_LONG_CYCLES_DEF`
  - helper function for counter widths
- Sub-module `btn_chan`:
  - one channel: sync, debounce, edge detect, long counter and toggle
  - scalar ports plus DB_CYCLES, LONG_CYCLES and ACTIVE_LOW
- `btn_bank`: generate loop instantiating `btn_chan` N_BTN times, with polarity applied per channel.

## Test plan
All scenarios use N_BTN=2, DB_CYCLES=8, LONG_CYCLES=32, ACTIVE_LOW=0 unless stated.
- Clean press on ch0, held 20 cycles:
  - btn_level[0] rises at edge 9.
  - press_pulse[0] is high 1 cycle after edge 10.
  - toggle[0] = 1.
  - ch1 outputs stay 0.
- Bounce: ch0 high 7 cycles, low 1, high 7, then low → no output change, dcnt returns to 0.
- Long press on ch1, held 60 cycles:
  - long_pulse[1] is high once, after edge 41.
  - On release, release_pulse[1] fires once and long_pulse does not repeat.
- Short press: held 20 cycles then released → no long_pulse; release_pulse fires 10 edges after the pin falls.
- Reset mid-hold: rst_n low for 3 cycles at cycle 25 of a hold, with the pin still high:
  - All outputs go to 0 immediately, asynchronously.
  - After release of reset, press_pulse refires 10 edges later.
- ACTIVE_LOW=1: pins idle at 1 and are driven to 0 for 20 cycles → same responses as the clean-press scenario.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared constants and helpers for the push-button front end.
package btn_pkg;

  // Board-level defaults: roughly 1 ms debounce and 0.5 s long press at 100 MHz.
  localparam int BTN_DB_CYCLES_DEF   = 100000;
  localparam int BTN_LONG_CYCLES_DEF = 50000000;

  // Bits needed to hold values 0..v-1; never narrower than one bit.
  function automatic int btn_cnt_width(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: polarity, two-flop sync, debounce, edge pulses,
// long-press detector and press toggle.
module btn_chan
  import btn_pkg::*;
#(
  parameter int DB_CYCLES   = BTN_DB_CYCLES_DEF,
  parameter int LONG_CYCLES = BTN_LONG_CYCLES_DEF,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic toggle
);

  localparam int DW = btn_cnt_width(DB_CYCLES);
  localparam int LW = btn_cnt_width(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0] LONG_SAT  = LW'(LONG_CYCLES);

  logic          pin;
  logic          s1;
  logic          s2;
  logic          db;
  logic          db_q;
  logic [DW-1:0] dcnt;
  logic [LW-1:0] lcnt;

  // Normalise so that 1 always means pressed before anything is sampled.
  assign pin   = (ACTIVE_LOW != 0) ? ~pin_raw : pin_raw;
  assign level = db;

  // Two-flop synchroniser; resets to the released level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;
    end
  end

  // Accept a new level only after it has differed from db for DB_CYCLES samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db   <= 1'b0;
      dcnt <= '0;
    end else if (s2 == db) begin
      dcnt <= '0;
    end else if (dcnt == DB_LAST) begin
      db   <= s2;
      dcnt <= '0;
    end else begin
      dcnt <= dcnt + DW'(1);
    end
  end

  // Registered edge pulses and toggle from the debounced level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q          <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      toggle        <= 1'b0;
    end else begin
      db_q          <= db;
      press_pulse   <= db & ~db_q;
      release_pulse <= ~db & db_q;
      toggle        <= toggle ^ (db & ~db_q);
    end
  end

  // Hold counter saturates so the long pulse fires only once per press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcnt       <= '0;
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= db & (lcnt == LONG_LAST);
      if (!db) begin
        lcnt <= '0;
      end else if (lcnt != LONG_SAT) begin
        lcnt <= lcnt + LW'(1);
      end
    end
  end

endmodule

// File: rtl/btn_bank.sv
// Bank of independent debounced button channels.
module btn_bank
  import btn_pkg::*;
#(
  parameter int N_BTN       = 4,
  parameter int DB_CYCLES   = BTN_DB_CYCLES_DEF,
  parameter int LONG_CYCLES = BTN_LONG_CYCLES_DEF,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_pulse,
  output logic [N_BTN-1:0] toggle
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_chan #(
      .DB_CYCLES  (DB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .pin_raw      (btn_raw[i]),
      .level        (btn_level[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_pulse   (long_pulse[i]),
      .toggle       (toggle[i])
    );
  end

endmodule

// File: tb/tb_btn_bank.sv
// Scoreboard bench for btn_bank: an active-high-pin and an active-low-pin
// instance share clock and reset; expected output values are queued with
// the cycle they are due at and compared on the falling edge.
module tb_btn_bank;

  localparam int N    = 2;
  localparam int DB   = 8;
  localparam int LONG = 32;

  localparam int K_LEVEL = 0;
  localparam int K_PRESS = 1;
  localparam int K_REL   = 2;
  localparam int K_LONG  = 3;
  localparam int K_TOG   = 4;

  typedef struct {
    int   cyc;
    int   inst;
    int   ch;
    int   kind;
    logic val;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_raw_al = '1;
  logic [N-1:0] lvl0, prs0, rel0, lng0, tog0;
  logic [N-1:0] lvl1, prs1, rel1, lng1, tog1;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic tog_exp [2][N];

  btn_bank #(.N_BTN(N), .DB_CYCLES(DB), .LONG_CYCLES(LONG), .ACTIVE_LOW(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .btn_level(lvl0), .press_pulse(prs0), .release_pulse(rel0),
    .long_pulse(lng0), .toggle(tog0)
  );

  btn_bank #(.N_BTN(N), .DB_CYCLES(DB), .LONG_CYCLES(LONG), .ACTIVE_LOW(1)) u_dut_al (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw_al),
    .btn_level(lvl1), .press_pulse(prs1), .release_pulse(rel1),
    .long_pulse(lng1), .toggle(tog1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic getOut(input int inst, input int kind, input int ch);
    logic [N-1:0] v;
    v = '0;
    case (kind)
      K_LEVEL: v = (inst == 0) ? lvl0 : lvl1;
      K_PRESS: v = (inst == 0) ? prs0 : prs1;
      K_REL:   v = (inst == 0) ? rel0 : rel1;
      K_LONG:  v = (inst == 0) ? lng0 : lng1;
      default: v = (inst == 0) ? tog0 : tog1;
    endcase
    return v[ch];
  endfunction

  function automatic string kindName(input int kind);
    case (kind)
      K_LEVEL: return "level";
      K_PRESS: return "press";
      K_REL:   return "release";
      K_LONG:  return "long";
      default: return "toggle";
    endcase
  endfunction

  // Compare every expectation due in the current cycle, away from the active edge.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        checkOutput($sformatf("%s_i%0d_c%0d_at%0d", kindName(sb[i].kind), sb[i].inst,
                              sb[i].ch, sb[i].cyc),
                    32'(getOut(sb[i].inst, sb[i].kind, sb[i].ch)), 32'(sb[i].val));
        sb.delete(i);
      end
    end
  end

  task automatic pushExp(input int c, input int inst, input int ch, input int kind, input logic v);
    exp_t e;
    e.cyc = c; e.inst = inst; e.ch = ch; e.kind = kind; e.val = v;
    sb.push_back(e);
  endtask

  // b is the cycle number of edge 0 for the new pressed level.
  task automatic pushPress(input int inst, input int ch, input int b);
    pushExp(b + DB,     inst, ch, K_LEVEL, 1'b0);
    pushExp(b + DB + 1, inst, ch, K_LEVEL, 1'b1);
    pushExp(b + DB + 1, inst, ch, K_PRESS, 1'b0);
    pushExp(b + DB + 2, inst, ch, K_PRESS, 1'b1);
    pushExp(b + DB + 3, inst, ch, K_PRESS, 1'b0);
    pushExp(b + DB + 2, inst, ch, K_REL,   1'b0);
    pushExp(b + DB + 1, inst, ch, K_TOG,   tog_exp[inst][ch]);
    tog_exp[inst][ch] = ~tog_exp[inst][ch];
    pushExp(b + DB + 2, inst, ch, K_TOG,   tog_exp[inst][ch]);
  endtask

  task automatic pushRelease(input int inst, input int ch, input int r);
    pushExp(r + DB,     inst, ch, K_LEVEL, 1'b1);
    pushExp(r + DB + 1, inst, ch, K_LEVEL, 1'b0);
    pushExp(r + DB + 1, inst, ch, K_REL,   1'b0);
    pushExp(r + DB + 2, inst, ch, K_REL,   1'b1);
    pushExp(r + DB + 3, inst, ch, K_REL,   1'b0);
    pushExp(r + DB + 2, inst, ch, K_PRESS, 1'b0);
    pushExp(r + DB + 2, inst, ch, K_LONG,  1'b0);
    pushExp(r + DB + 2, inst, ch, K_TOG,   tog_exp[inst][ch]);
  endtask

  task automatic pushQuiet(input int inst, input int ch, input int b);
    pushExp(b + DB + 1, inst, ch, K_LEVEL, 1'b0);
    pushExp(b + DB + 2, inst, ch, K_PRESS, 1'b0);
    pushExp(b + DB + 2, inst, ch, K_TOG,   tog_exp[inst][ch]);
    pushExp(b + DB + 1 + LONG, inst, ch, K_LONG, 1'b0);
  endtask

  task automatic setPin(input int inst, input int ch, input logic pressed);
    if (inst == 0) btn_raw[ch] = pressed;
    else           btn_raw_al[ch] = ~pressed;
  endtask

  // Press one channel for 'hold' edges, release, and queue everything that must follow.
  task automatic applyStimulus(input int inst, input int ch, input int hold);
    int b;
    int r;
    @(posedge clk); #1;
    setPin(inst, ch, 1'b1);
    b = cyc + 1;
    r = b + hold;
    pushPress(inst, ch, b);
    pushQuiet(inst, 1 - ch, b);
    pushQuiet(1 - inst, ch, b);
    if (hold >= LONG) begin
      pushExp(b + DB + LONG,     inst, ch, K_LONG, 1'b0);
      pushExp(b + DB + 1 + LONG, inst, ch, K_LONG, 1'b1);
      pushExp(b + DB + 2 + LONG, inst, ch, K_LONG, 1'b0);
    end else begin
      pushExp(b + DB + 1 + LONG, inst, ch, K_LONG, 1'b0);
    end
    pushRelease(inst, ch, r);
    repeat (hold) @(posedge clk);
    #1 setPin(inst, ch, 1'b0);
    repeat (25) @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int b;
    int r;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < N; j++)
        tog_exp[i][j] = 1'b0;

    $display("[TB] reset state");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_level", 32'({lvl1, lvl0}), 32'd0);
    checkOutput("rst_press", 32'({prs1, prs0, rel1, rel0}), 32'd0);
    checkOutput("rst_long_tog", 32'({lng1, lng0, tog1, tog0}), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    $display("[TB] clean short press ch0");
    applyStimulus(0, 0, 20);

    $display("[TB] bounce ch0");
    @(posedge clk); #1;
    b = cyc + 1;
    setPin(0, 0, 1'b1);
    for (int k = 0; k < 30; k++) begin
      pushExp(b + k, 0, 0, K_LEVEL, 1'b0);
      pushExp(b + k, 0, 0, K_PRESS, 1'b0);
      pushExp(b + k, 0, 0, K_REL,   1'b0);
    end
    repeat (7) @(posedge clk);
    #1 setPin(0, 0, 1'b0);
    @(posedge clk);
    #1 setPin(0, 0, 1'b1);
    repeat (7) @(posedge clk);
    #1 setPin(0, 0, 1'b0);
    repeat (20) @(posedge clk);
    #1 checkOutput("bounce_dcnt", 32'(u_dut.g_chan[0].u_chan.dcnt), 32'd0);

    $display("[TB] long press ch1");
    applyStimulus(0, 1, 60);

    $display("[TB] reset mid-hold ch0");
    @(posedge clk); #1;
    setPin(0, 0, 1'b1);
    b = cyc + 1;
    pushPress(0, 0, b);
    repeat (25) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rstmid_level", 32'(lvl0), 32'd0);
    checkOutput("rstmid_pulses", 32'({prs0, rel0, lng0}), 32'd0);
    checkOutput("rstmid_toggle", 32'(tog0), 32'd0);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < N; j++)
        tog_exp[i][j] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    b = cyc + 1;
    pushPress(0, 0, b);
    repeat (20) @(posedge clk);
    #1 setPin(0, 0, 1'b0);
    r = cyc + 1;
    pushRelease(0, 0, r);
    repeat (25) @(posedge clk);

    $display("[TB] simultaneous press ch0+ch1");
    @(posedge clk); #1;
    setPin(0, 0, 1'b1);
    setPin(0, 1, 1'b1);
    b = cyc + 1;
    pushPress(0, 0, b);
    pushPress(0, 1, b);
    repeat (12) @(posedge clk);
    #1 setPin(0, 0, 1'b0);
    setPin(0, 1, 1'b0);
    r = cyc + 1;
    pushRelease(0, 0, r);
    pushRelease(0, 1, r);
    repeat (25) @(posedge clk);

    $display("[TB] active-low instance ch0");
    applyStimulus(1, 0, 20);

    repeat (5) @(posedge clk);
    #1 checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
